// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the scoreboarded register file:
//   state_e   - controller state (SWEEP zeroes the array, READY serves traffic)
//   XLEN_DEF  - default data width
//   NREGS_DEF - default register count
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_sb_score.sv
// regfile_sb_score
// Pending-bit array. One bit per register. A bit is set when an instruction
// that will write the register issues, and cleared when its writeback lands.
// Ports:
//   clk, rst_n        - clock, async active-low reset (clears all bits)
//   clr_all           - clear every bit at the next edge (dominates set/clear)
//   set_en / set_idx  - mark set_idx pending at the next edge
//   clr_en / clr_idx  - mark clr_idx not pending at the next edge
//   rd_idx1/2, hit1/2 - combinational lookup of the current pending bits
// Entry 0 is hard-wired to "not pending".
module regfile_sb_score
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_all,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rd_idx1,
  input  logic [AW-1:0] rd_idx2,
  output logic          hit1,
  output logic          hit2
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  // Clear is applied before set so an issue and a writeback to the same
  // register in one cycle leave the bit set: the new producer is still in
  // flight.
  always_comb begin
    pend_d = pend_q;
    if (clr_all) begin
      pend_d = '0;
    end else begin
      if (clr_en) pend_d[clr_idx] = 1'b0;
      if (set_en) pend_d[set_idx] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign hit1 = pend_q[rd_idx1];
  assign hit2 = pend_q[rd_idx2];

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// Two-read / one-write register file with a pending-bit scoreboard and a
// zeroing sweep after reset or on request.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   clr                             - request a zeroing sweep (ignored mid-sweep)
//   ready                           - 1 once the sweep is done; traffic accepted
//   we, writeaddr, writedata        - writeback port
//   iss_valid, iss_rd               - issue of an instruction that will write iss_rd
//   readaddr1/2, readdata1/2        - combinational read ports with write bypass
//   busy1/2                         - addressed register has a pending value
//
// state | meaning
// SWEEP | writing 0 to entry cnt each cycle; traffic ignored, outputs forced 0
// READY | normal operation; clr starts a new sweep
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  output logic            ready,
  input  logic            we,
  input  logic [AW-1:0]   writeaddr,
  input  logic [XLEN-1:0] writedata,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   readaddr1,
  input  logic [AW-1:0]   readaddr2,
  output logic [XLEN-1:0] readdata1,
  output logic [XLEN-1:0] readdata2,
  output logic            busy1,
  output logic            busy2
);

  localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0] mem_q [NREGS];
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;

  logic            pend_clr_all;
  logic            pend_set;
  logic            pend_clr;
  logic            hit1, hit2;
  logic            byp1, byp2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      SWEEP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      READY: begin
        if (clr) state_d = SWEEP;
      end
      default: state_d = SWEEP;
    endcase
  end

  // Outputs / datapath controls. Traffic in the cycle clr is seen is dropped
  // so nothing leaks into the freshly swept array.
  always_comb begin
    ready        = 1'b0;
    mem_we       = 1'b0;
    mem_wa       = '0;
    mem_wd       = '0;
    pend_clr_all = 1'b1;
    pend_set     = 1'b0;
    pend_clr     = 1'b0;
    case (state_q)
      SWEEP: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
      end
      READY: begin
        ready        = 1'b1;
        pend_clr_all = clr;
        mem_we       = we && (writeaddr != '0) && !clr;
        mem_wa       = writeaddr;
        mem_wd       = writedata;
        pend_set     = iss_valid && (iss_rd != '0) && !clr;
        pend_clr     = we && !clr;
      end
      default: ;
    endcase
  end

  // Storage carries no reset so it can map onto RAM; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  regfile_sb_score #(
    .NREGS (NREGS)
  ) u_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_all (pend_clr_all),
    .set_en  (pend_set),
    .set_idx (iss_rd),
    .clr_en  (pend_clr),
    .clr_idx (writeaddr),
    .rd_idx1 (readaddr1),
    .rd_idx2 (readaddr2),
    .hit1    (hit1),
    .hit2    (hit2)
  );

  // A writeback to the read index in the same cycle forwards its data and
  // resolves the hazard.
  assign byp1 = we && (writeaddr == readaddr1);
  assign byp2 = we && (writeaddr == readaddr2);

  always_comb begin
    readdata1 = '0;
    if (ready && (readaddr1 != '0)) begin
      readdata1 = byp1 ? writedata : mem_q[readaddr1];
    end
  end

  always_comb begin
    readdata2 = '0;
    if (ready && (readaddr2 != '0)) begin
      readdata2 = byp2 ? writedata : mem_q[readaddr2];
    end
  end

  assign busy1 = ready && hit1 && !byp1;
  assign busy2 = ready && hit2 && !byp2;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main instance: XLEN=32, NREGS=32 ----------------
  logic        rst_n = 1'b1;
  logic        clr = 1'b0, we = 1'b0, iss_valid = 1'b0;
  logic [4:0]  writeaddr = '0, iss_rd = '0, readaddr1 = '0, readaddr2 = '0;
  logic [31:0] writedata = '0;
  logic        ready, busy1, busy2;
  logic [31:0] readdata1, readdata2;

  regfile_sb #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready),
    .we(we), .writeaddr(writeaddr), .writedata(writedata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .readaddr1(readaddr1), .readaddr2(readaddr2),
    .readdata1(readdata1), .readdata2(readdata2),
    .busy1(busy1), .busy2(busy2)
  );

  // ---------------- second instance: XLEN=64, NREGS=16 ----------------
  logic        b_rst_n = 1'b1;
  logic        b_clr = 1'b0, b_we = 1'b0, b_iss_valid = 1'b0;
  logic [3:0]  b_writeaddr = '0, b_iss_rd = '0, b_readaddr1 = '0, b_readaddr2 = '0;
  logic [63:0] b_writedata = '0;
  logic        b_ready, b_busy1, b_busy2;
  logic [63:0] b_readdata1, b_readdata2;

  regfile_sb #(.XLEN(64), .NREGS(16)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .clr(b_clr), .ready(b_ready),
    .we(b_we), .writeaddr(b_writeaddr), .writedata(b_writedata),
    .iss_valid(b_iss_valid), .iss_rd(b_iss_rd),
    .readaddr1(b_readaddr1), .readaddr2(b_readaddr2),
    .readdata1(b_readdata1), .readdata2(b_readdata2),
    .busy1(b_busy1), .busy2(b_busy2)
  );

  // Edges until ready rises on the main instance, bounded.
  task automatic wait_ready(input string tag, input int exp_cyc);
    int cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!ready && cyc < 200);
    chk(tag, 64'(cyc), 64'(exp_cyc));
  endtask

  initial begin
    logic [31:0] acc;
    logic        bacc;
    int          cyc;

    // ---- reset and initial sweep ----
    #3 rst_n = 1'b0; b_rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rd1", 64'(readdata1), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 31) chk("sweep_c31_ready", 64'(ready), 64'd0);
    end while (!ready && cyc < 200);
    chk("sweep_len", 64'(cyc), 64'd32);
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      readaddr1 = 5'(i); readaddr2 = 5'(31 - i);
      #1 acc = acc | readdata1 | readdata2;
    end
    chk("post_sweep_zero", 64'(acc), 64'd0);

    // ---- write / read / bypass ----
    tick();
    we = 1'b1; writeaddr = 5'd5; writedata = 32'hDEADBEEF; readaddr1 = 5'd5; readaddr2 = 5'd0;
    #1 chk("bypass_r5", 64'(readdata1), 64'hDEADBEEF);
    chk("bypass_r0_port2", 64'(readdata2), 64'd0);
    tick();
    we = 1'b0; readaddr1 = 5'd5; readaddr2 = 5'd5;
    #1 chk("read1_r5", 64'(readdata1), 64'hDEADBEEF);
    chk("read2_r5", 64'(readdata2), 64'hDEADBEEF);
    we = 1'b1; writeaddr = 5'd0; writedata = 32'hFFFF_FFFF; readaddr1 = 5'd0;
    #1 chk("r0_no_bypass", 64'(readdata1), 64'd0);
    tick();
    we = 1'b0;
    #1 chk("r0_after_write", 64'(readdata1), 64'd0);

    // ---- issue / writeback / busy ----
    iss_valid = 1'b1; iss_rd = 5'd7; readaddr1 = 5'd7;
    #1 chk("busy_same_cycle_issue", 64'(busy1), 64'd0);
    tick();
    iss_valid = 1'b0;
    #1 chk("busy_r7", 64'(busy1), 64'd1);
    we = 1'b1; writeaddr = 5'd7; writedata = 32'h1234;
    #1 chk("busy_wb_bypass", 64'(busy1), 64'd0);
    chk("data_wb_bypass", 64'(readdata1), 64'h1234);
    tick();
    we = 1'b0;
    #1 chk("busy_after_wb", 64'(busy1), 64'd0);
    chk("data_after_wb", 64'(readdata1), 64'h1234);
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    iss_valid = 1'b0; readaddr2 = 5'd0;
    #1 chk("r0_never_busy", 64'(busy2), 64'd0);

    // ---- issue and writeback same register same cycle ----
    iss_valid = 1'b1; iss_rd = 5'd9; we = 1'b1; writeaddr = 5'd9; writedata = 32'h55;
    tick();
    iss_valid = 1'b0; we = 1'b0; readaddr1 = 5'd9; readaddr2 = 5'd9;
    #1 chk("issue_wins_busy1", 64'(busy1), 64'd1);
    chk("issue_wins_data2", 64'(readdata2), 64'h55);

    // ---- fill, pend r3, clr sweep ----
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; writeaddr = 5'(i); writedata = 32'h0101_0101 * 32'(i) + 32'h10;
      tick();
    end
    we = 1'b0; readaddr1 = 5'd31; readaddr2 = 5'd17;
    #1 chk("fill_r31", 64'(readdata1), 64'h1F1F_1F2F);
    chk("fill_r17", 64'(readdata2), 64'h1111_1121);
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    iss_valid = 1'b0; readaddr1 = 5'd3;
    #1 chk("pend_r3", 64'(busy1), 64'd1);
    clr = 1'b1; we = 1'b1; writeaddr = 5'd12; writedata = 32'hABCD; iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    clr = 1'b0; we = 1'b0; iss_valid = 1'b0; readaddr1 = 5'd31; readaddr2 = 5'd3;
    #1 chk("clr_ready_low", 64'(ready), 64'd0);
    cyc = 0;
    do begin
      // stray clr and traffic mid-sweep must neither restart nor leak through
      clr = (cyc == 5); we = (cyc == 6); iss_valid = (cyc == 6);
      writeaddr = 5'd20; writedata = 32'h77; iss_rd = 5'd20;
      #1;
      if (cyc == 3) begin
        chk("sweep_rd_forced0", 64'(readdata1), 64'd0);
        chk("sweep_busy_forced0", 64'(busy2), 64'd0);
      end
      tick();
      cyc++;
    end while (!ready && cyc < 200);
    clr = 1'b0; we = 1'b0; iss_valid = 1'b0;
    chk("clr_sweep_len", 64'(cyc), 64'd32);
    acc = '0; bacc = 1'b0;
    for (int i = 0; i < 32; i++) begin
      readaddr1 = 5'(i); readaddr2 = 5'(i);
      #1 acc = acc | readdata1; bacc = bacc | busy2;
    end
    chk("clr_all_zero", 64'(acc), 64'd0);
    chk("clr_no_busy", 64'(bacc), 64'd0);

    // ---- reset mid-sweep ----
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    chk("mid_sweep_ready", 64'(ready), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready("reset_restart_len", 32);

    // ---- 64-bit / 16-entry instance ----
    b_rst_n = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!b_ready && cyc < 200);
    chk("b_sweep_len", 64'(cyc), 64'd16);
    b_readaddr1 = 4'd15;
    #1 chk("b_r15_zero", b_readdata1, 64'd0);
    b_we = 1'b1; b_writeaddr = 4'd5; b_writedata = 64'hDEADBEEF_CAFEF00D; b_readaddr1 = 4'd5;
    #1 chk("b_bypass_r5", b_readdata1, 64'hDEADBEEF_CAFEF00D);
    tick();
    b_we = 1'b0; b_readaddr2 = 4'd5;
    #1 chk("b_read_r5", b_readdata2, 64'hDEADBEEF_CAFEF00D);
    b_iss_valid = 1'b1; b_iss_rd = 4'd7;
    tick();
    b_iss_valid = 1'b0; b_readaddr1 = 4'd7;
    #1 chk("b_busy_r7", 64'(b_busy1), 64'd1);
    b_we = 1'b1; b_writeaddr = 4'd7; b_writedata = 64'h1234;
    #1 chk("b_busy_wb", 64'(b_busy1), 64'd0);
    chk("b_data_wb", b_readdata1, 64'h1234);
    tick();
    b_we = 1'b0;
    #1 chk("b_busy_after", 64'(b_busy1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
